// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage
//
// Instruction-fetch stage of the LEGv8 pipeline. It holds the program counter
// and presents it as a byte address to a combinational instruction memory.
// The returned word is captured into the IF/ID pipeline register on the next
// rising edge. The stage handles stall, flush and taken-branch redirect. It
// halts (fetch_fault) when the PC leaves the populated memory range or is
// misaligned. A branch to a fetchable address recovers from the halt.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset (priority over all)
//   stall             hold PC and IF/ID contents
//   flush             squash IF/ID contents (bubble)
//   branch_taken      redirect request
//   branch_target     redirect byte address
//   imem_adr          byte address to instruction memory (= pc)
//   imem_instruction  combinational read data from instruction memory
//   if_id_pc          PC of the captured instruction
//   if_id_instruction captured instruction word
//   if_id_valid       captured instruction is real (not a bubble)
//   fetch_fault       set while halted
//   fetched_count     valid instructions captured, saturating
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] imem_adr,
    input  logic [31:0] imem_instruction,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetched_count
);

    // Highest byte address that still holds a whole instruction.
    localparam logic [63:0] LAST_ADR = 64'(IMEM_BYTES - 4);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state_reg;
    logic [63:0] pc_reg;

    // Full 64-bit unsigned compare: a pc that wrapped past 2^64 lands far
    // above LAST_ADR (or back at a legal low address) and is judged as such.
    function automatic logic fetchable(input logic [63:0] adr);
        return (adr[1:0] == 2'b00) && (adr <= LAST_ADR);
    endfunction

    logic        pc_in_range;
    logic [63:0] pc_plus4;

    assign pc_in_range = fetchable(pc_reg);
    assign pc_plus4    = pc_reg + 64'd4;
    assign imem_adr    = pc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= RUN;
            pc_reg            <= RESET_PC;
            if_id_pc          <= 64'h0;
            if_id_instruction <= 32'h0;
            if_id_valid       <= 1'b0;
            fetch_fault       <= 1'b0;
            fetched_count     <= 32'h0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (branch_taken) begin
                        // Redirect wins over stall and flush.
                        pc_reg            <= branch_target;
                        if_id_pc          <= 64'h0;
                        if_id_instruction <= 32'h0;
                        if_id_valid       <= 1'b0;
                    end else if (flush) begin
                        if (!stall) begin
                            pc_reg <= pc_plus4;
                        end
                        if_id_pc          <= 64'h0;
                        if_id_instruction <= 32'h0;
                        if_id_valid       <= 1'b0;
                    end else if (stall) begin
                        // Everything holds.
                    end else if (pc_in_range) begin
                        if_id_pc          <= pc_reg;
                        if_id_instruction <= imem_instruction;
                        if_id_valid       <= 1'b1;
                        pc_reg            <= pc_plus4;
                        if (fetched_count != 32'hFFFF_FFFF) begin
                            fetched_count <= fetched_count + 32'd1;
                        end
                    end else begin
                        // PC left the populated range: park here with pc held
                        // so the faulting address stays visible on imem_adr.
                        state_reg         <= HALT;
                        fetch_fault       <= 1'b1;
                        if_id_pc          <= 64'h0;
                        if_id_instruction <= 32'h0;
                        if_id_valid       <= 1'b0;
                    end
                end

                HALT: begin
                    // Stall and flush have no effect while halted.
                    if_id_pc          <= 64'h0;
                    if_id_instruction <= 32'h0;
                    if_id_valid       <= 1'b0;
                    if (branch_taken) begin
                        pc_reg <= branch_target;
                        if (fetchable(branch_target)) begin
                            state_reg   <= RUN;
                            fetch_fault <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage
//
// Directed walk through the fetch stage's main scenarios, followed by a
// randomized phase. A behavioural model of the stage predicts every output
// after each clock edge, and after each asynchronous reset pulse.
// Instruction memory is 16 bytes (4 words).
// ============================================================================
module tb_fetch_stage;

    localparam int MEM_BYTES = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [63:0] imem_adr;
    logic [31:0] imem_instruction;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetched_count;

    logic [31:0] mem [0:3];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic [63:0] m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_count;
    bit          m_halted;

    fetch_stage #(
        .RESET_PC  (64'h0),
        .IMEM_BYTES(MEM_BYTES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_adr         (imem_adr),
        .imem_instruction (imem_instruction),
        .if_id_pc         (if_id_pc),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid),
        .fetch_fault      (fetch_fault),
        .fetched_count    (fetched_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory; outside the populated range it
    // returns a recognisable junk word that must never be captured.
    assign imem_instruction = (imem_adr < 64'(MEM_BYTES)) ? mem[imem_adr[3:2]] : 32'hDEAD_BEEF;

    function automatic bit legal_fetch(input logic [63:0] a);
        return (a % 4 == 0) && (a + 4 <= 64'(MEM_BYTES)) && (a < 64'(MEM_BYTES));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_adr"}, imem_adr, m_pc);
        chk({tag, ".if_id_pc"}, if_id_pc, m_ifpc);
        chk({tag, ".instr"}, 64'(if_id_instruction), 64'(m_instr));
        chk({tag, ".valid"}, 64'(if_id_valid), 64'(m_valid));
        chk({tag, ".fault"}, 64'(fetch_fault), 64'(m_fault));
        chk({tag, ".count"}, 64'(fetched_count), 64'(m_count));
        $display("[%0t] %s pc=%0h if_id_pc=%0h instr=%h valid=%0b fault=%0b count=%0d",
                 $time, tag, imem_adr, if_id_pc, if_id_instruction, if_id_valid,
                 fetch_fault, fetched_count);
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_ifpc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
        m_fault = 1'b0; m_count = 32'h0; m_halted = 1'b0;
    endtask

    task automatic model_bubble();
        m_ifpc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    endtask

    // What one rising edge does, given the present inputs.
    task automatic model_edge();
        if (m_halted) begin
            model_bubble();
            if (branch_taken) begin
                m_pc = branch_target;
                if (legal_fetch(branch_target)) begin
                    m_halted = 1'b0;
                    m_fault  = 1'b0;
                end
            end
        end else if (branch_taken) begin
            m_pc = branch_target;
            model_bubble();
        end else if (flush) begin
            if (!stall) m_pc = m_pc + 64'd4;
            model_bubble();
        end else if (stall) begin
            // nothing changes
        end else if (legal_fetch(m_pc)) begin
            m_ifpc  = m_pc;
            m_instr = mem[m_pc / 4];
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            if (m_count < 32'hFFFF_FFFF) m_count = m_count + 1;
        end else begin
            m_halted = 1'b1;
            m_fault  = 1'b1;
            model_bubble();
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic bt, input logic [63:0] tgt);
        stall = st; flush = fl; branch_taken = bt; branch_target = tgt;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Pulse reset between edges and check the outputs before any clock edge.
    task automatic reset_pulse(input string tag);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [63:0] tgt;
        int r;

        mem[0] = 32'h8B1F03E5; mem[1] = 32'hF84000A4;
        mem[2] = 32'h8B040086; mem[3] = 32'hF80010A6;
        drive(0, 0, 0, 64'h0);

        // Reset, asserted away from any clock edge.
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        reset = 1'b0;

        // Capture 0, then stall two edges, then continue sequentially.
        step("seq0");
        drive(1, 0, 0, 64'h0);
        step("stall1");
        step("stall2");
        chk("stall_adr", imem_adr, 64'd4);
        chk("stall_instr", 64'(if_id_instruction), 64'h8B1F03E5);
        drive(0, 0, 0, 64'h0);
        step("seq4");
        chk("seq4_instr", 64'(if_id_instruction), 64'hF84000A4);
        step("seq8");
        step("seq12");
        chk("seq12_pc", if_id_pc, 64'd12);
        chk("seq_count", 64'(fetched_count), 64'd4);

        // Run off the end of the 16-byte memory.
        step("halt_enter");
        chk("halt_fault", 64'(fetch_fault), 64'd1);
        drive(1, 1, 0, 64'h0);
        step("halt_ignore_stall_flush");
        chk("halt_adr", imem_adr, 64'd16);
        chk("halt_count", 64'(fetched_count), 64'd4);

        // Recover with a branch to 4.
        drive(0, 0, 1, 64'd4);
        step("halt_recover");
        chk("recover_fault", 64'(fetch_fault), 64'd0);
        drive(0, 0, 0, 64'h0);
        step("resume4");
        chk("resume4_instr", 64'(if_id_instruction), 64'hF84000A4);
        chk("resume4_pc", if_id_pc, 64'd4);

        // Back to pc=4, then branch to 12 while stalled.
        drive(0, 0, 1, 64'd4);
        step("redir4");
        drive(1, 0, 1, 64'd12);
        step("branch_over_stall");
        chk("bos_valid", 64'(if_id_valid), 64'd0);
        chk("bos_pc", imem_adr, 64'd12);
        drive(0, 0, 0, 64'h0);
        step("after_branch");
        chk("ab_instr", 64'(if_id_instruction), 64'hF80010A6);
        step("halt_again");

        // Resume at 0, then take a misaligned redirect to 6.
        drive(0, 0, 1, 64'd0);
        step("resume0");
        drive(0, 0, 0, 64'h0);
        step("cap0");
        drive(0, 0, 1, 64'd6);
        step("misaligned_redir");
        chk("mis_fault_pre", 64'(fetch_fault), 64'd0);
        drive(0, 0, 0, 64'h0);
        step("misaligned_halt");
        chk("mis_fault", 64'(fetch_fault), 64'd1);

        // Out-of-range target while halted: pc moves to 16, still halted.
        drive(0, 0, 1, 64'd16);
        step("halt_oor_branch");
        drive(0, 0, 0, 64'h0);
        step("halt_pc16");

        // Asynchronous reset mid-HALT, then first fetch from 0.
        reset_pulse("async_reset");
        step("post_reset");
        chk("post_reset_instr", 64'(if_id_instruction), 64'h8B1F03E5);
        chk("post_reset_pc", if_id_pc, 64'd0);

        // Randomized phase with fresh memory contents.
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3, 4, 5: tgt = 64'($urandom_range(0, 4)) * 4;
                6:                tgt = 64'($urandom_range(0, 19));
                7:                tgt = 64'hFFFF_FFFF_FFFF_FFFC;
                8:                tgt = {$urandom, $urandom};
                default:          tgt = 64'd12;
            endcase
            drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0), tgt);
            if ($urandom_range(0, 60) == 0) begin
                reset_pulse($sformatf("rnd_reset%0d", n));
            end else begin
                step($sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
